// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared types and constants for the immediate generator:
//                the immediate-format select encoding and FIFO sizing.
//                Optional feature macro: IMM_GEN_RVC_EN (compressed formats).
//  Revision    : 1.0  initial release
// ============================================================================
package imm_pkg;

    // Depth of the output skid FIFO
    localparam int IMM_FIFO_DEPTH = 2;

    // Widest supported immediate; the decoder always builds this width
    localparam int XLEN_MAX = 64;

    // Immediate format select; codes not listed here are reserved
    typedef enum logic [3:0] {
        IMM_I     = 4'd0,
        IMM_S     = 4'd1,
        IMM_B     = 4'd2,
        IMM_U     = 4'd3,
        IMM_J     = 4'd4,
        IMM_SHAMT = 4'd5,
        IMM_ZIMM  = 4'd6,
        IMM_CI    = 4'd8,
        IMM_CB    = 4'd9,
        IMM_CJ    = 4'd10
    } imm_src_e;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_gen_core.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_core
//  Description : Purely combinational immediate decode. Extracts and
//                sign/zero-extends the immediate selected by imm_src and
//                flags reserved or disabled selects (imm forced to zero).
//                Optional feature macro: IMM_GEN_RVC_EN enables the
//                compressed CI/CB/CJ formats (codes 8-10).
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    input  imm_src_e         imm_src,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    // Full-width immediate before trimming to XLEN
    logic [XLEN_MAX-1:0] w_full;
    // Zero-extended shift amount; field width depends on XLEN
    logic [5:0]          w_shamt;
    // Bits that some configurations never look at
    logic                w_unused;

    generate
        if (XLEN == 64) begin : g_shamt64
            assign w_shamt = instr[25:20];
        end else begin : g_shamt32
            assign w_shamt = {1'b0, instr[24:20]};
        end
    endgenerate

    // Format select: build the extended immediate at full width
    always_comb begin
        w_full  = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:     w_full = {{52{instr[31]}}, instr[31:20]};
            IMM_S:     w_full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     w_full = {{51{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
            // U-type sign-extends from bit 31 when XLEN is 64
            IMM_U:     w_full = {{32{instr[31]}}, instr[31:12], 12'h000};
            IMM_J:     w_full = {{43{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: w_full = {58'd0, w_shamt};
            IMM_ZIMM:  w_full = {59'd0, instr[19:15]};
`ifdef IMM_GEN_RVC_EN
            IMM_CI:    w_full = {{58{instr[12]}}, instr[12], instr[6:2]};
            IMM_CB:    w_full = {{55{instr[12]}}, instr[12], instr[6:5], instr[2],
                                 instr[11:10], instr[4:3], 1'b0};
            IMM_CJ:    w_full = {{52{instr[12]}}, instr[12], instr[8], instr[10:9],
                                 instr[6], instr[7], instr[2], instr[11],
                                 instr[5:3], 1'b0};
`endif
            default: begin
                w_full  = '0;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = w_full[XLEN-1:0];

    // Opcode/quadrant bits and the upper half at XLEN=32 carry no immediate
    assign w_unused = &{1'b0, instr[6:0], w_full};

endmodule : imm_gen_core
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Registered immediate generator with valid/ready handshakes.
//                Decodes on input, stores the result in a 2-entry skid FIFO
//                (head entry drives out_*, second entry catches the item
//                accepted while the head is stalled). in_ready is registered.
//                Optional feature macro: IMM_GEN_RVC_EN (see imm_gen_core).
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [3:0]        in_imm_src,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    // Entry layout: {illegal, tag, imm}
    localparam int         c_ent_w = XLEN + TAG_W + 1;
    localparam logic [1:0] c_depth = 2'(IMM_FIFO_DEPTH);

    logic [XLEN-1:0]    w_dec_imm;
    logic               w_dec_ill;
    logic [c_ent_w-1:0] w_new_ent;

    logic [c_ent_w-1:0] r_head;
    logic [c_ent_w-1:0] r_skid;
    logic               r_head_vld;
    logic               r_skid_vld;
    logic               r_in_ready;

    logic [c_ent_w-1:0] w_head_nxt;
    logic [c_ent_w-1:0] w_skid_nxt;
    logic               w_head_vld_nxt;
    logic               w_skid_vld_nxt;
    logic [1:0]         w_cnt_nxt;
    logic               w_in_ready_nxt;

    logic               w_push;
    logic               w_pop;

    imm_gen_core #(
        .XLEN    (XLEN)
    ) u_core (
        .instr   (in_instr),
        .imm_src (imm_src_e'(in_imm_src)),
        .imm     (w_dec_imm),
        .illegal (w_dec_ill)
    );

    assign w_new_ent = {w_dec_ill, in_tag, w_dec_imm};
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = r_head_vld && out_ready;

    // FIFO next state: pop advances the second entry to head, then a push
    // lands in the first free slot so order is preserved
    always_comb begin
        w_head_nxt     = r_head;
        w_skid_nxt     = r_skid;
        w_head_vld_nxt = r_head_vld;
        w_skid_vld_nxt = r_skid_vld;
        if (w_pop) begin
            w_head_vld_nxt = r_skid_vld;
            w_skid_vld_nxt = 1'b0;
            if (r_skid_vld) begin
                w_head_nxt = r_skid;
            end
        end
        if (w_push) begin
            if (!w_head_vld_nxt) begin
                w_head_nxt     = w_new_ent;
                w_head_vld_nxt = 1'b1;
            end else begin
                w_skid_nxt     = w_new_ent;
                w_skid_vld_nxt = 1'b1;
            end
        end
        w_cnt_nxt      = {1'b0, w_head_vld_nxt} + {1'b0, w_skid_vld_nxt};
        w_in_ready_nxt = (w_cnt_nxt < c_depth);
    end

    // FIFO storage and registered ready; reset empties everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_skid     <= '0;
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_skid     <= w_skid_nxt;
            r_head_vld <= w_head_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_head_vld;
    assign out_imm     = r_head[XLEN-1:0];
    assign out_tag     = r_head[XLEN +: TAG_W];
    assign out_illegal = r_head[c_ent_w-1];

endmodule : imm_gen_pipe
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe. Two instances
//                (XLEN=32 and XLEN=64) share stimulus; a behavioural model
//                and an in-order queue supply expected results.
//                Optional feature macro: IMM_GEN_RVC_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] e64;
        logic [31:0] e32;
        logic [4:0]  tag;
        logic        ill;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [3:0]  in_imm_src = '0;
    logic [4:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        rdy32, rdy64, vld32, vld64, ill32, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    int n_checks = 0;
    int n_pass   = 0;
    sb_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_illegal(ill64)
    );

    // ---------------- reference model ----------------
    function automatic longint fld(input logic [31:0] ins, input int hi, input int lo);
        return (longint'(ins) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Interpret the low 'bits' bits of v as a two's complement number
    function automatic longint sx(input longint v, input int bits);
        longint m;
        longint t;
        m = longint'(1) << (bits - 1);
        t = v & ((longint'(1) << bits) - 1);
        return (t ^ m) - m;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [3:0] src,
                                            input int xlen, output logic ill);
        longint v;
        v   = 0;
        ill = 1'b0;
        case (src)
            4'd0: v = sx(fld(ins, 31, 20), 12);
            4'd1: v = sx(fld(ins, 31, 25) * 32 + fld(ins, 11, 7), 12);
            4'd2: v = sx(fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048
                         + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2, 13);
            4'd3: v = sx(fld(ins, 31, 12) * 4096, 32);
            4'd4: v = sx(fld(ins, 31, 31) * (1 << 20) + fld(ins, 19, 12) * 4096
                         + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2, 21);
            4'd5: v = (xlen == 64) ? fld(ins, 25, 20) : fld(ins, 24, 20);
            4'd6: v = fld(ins, 19, 15);
`ifdef IMM_GEN_RVC_EN
            4'd8: v = sx(fld(ins, 12, 12) * 32 + fld(ins, 6, 2), 6);
            4'd9: v = sx(fld(ins, 12, 12) * 256 + fld(ins, 6, 5) * 64 + fld(ins, 2, 2) * 32
                         + fld(ins, 11, 10) * 8 + fld(ins, 4, 3) * 2, 9);
            4'd10: v = sx(fld(ins, 12, 12) * 2048 + fld(ins, 8, 8) * 1024 + fld(ins, 10, 9) * 256
                          + fld(ins, 6, 6) * 128 + fld(ins, 7, 7) * 64 + fld(ins, 2, 2) * 32
                          + fld(ins, 11, 11) * 16 + fld(ins, 5, 3) * 2, 12);
`endif
            default: begin
                v   = 0;
                ill = 1'b1;
            end
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic sb_t mk_item(input logic [31:0] ins, input logic [3:0] src, input logic [4:0] tag);
        sb_t  it;
        logic i32;
        logic [63:0] r32;
        r32    = ref_imm(ins, src, 32, i32);
        it.e32 = r32[31:0];
        it.e64 = ref_imm(ins, src, 64, it.ill);
        it.tag = tag;
        return it;
    endfunction

    function automatic logic [3:0] rand_src();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 6));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({vld32, vld64, rdy32, rdy64, ill32, ill64} !== 6'b0 || imm32 !== 32'h0 ||
            imm64 !== 64'h0 || tag32 !== 5'h0 || tag64 !== 5'h0) begin
            $display("FAIL reset_state: valid=%b/%b ready=%b/%b ill=%b/%b imm=%h/%h tag=%h/%h, required all zero",
                     vld32, vld64, rdy32, rdy64, ill32, ill64, imm32, imm64, tag32, tag64);
        end else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
            $display("FAIL ready_before_edge: in_ready=%b/%b, required 0", rdy32, rdy64);
        end else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            $display("FAIL ready_after_release: in_ready=%b/%b, required 1", rdy32, rdy64);
        end else n_pass++;
    endtask

    // One item, downstream ready: result one cycle after acceptance, then gone
    task automatic test_vector(input string name, input logic [31:0] ins, input logic [3:0] src,
                               input logic [4:0] tag, input logic [31:0] x32,
                               input logic [63:0] x64, input logic xill);
        @(posedge clk); #1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_instr   = ins;
        in_imm_src = src;
        in_tag     = tag;
        @(negedge clk);
        n_checks++;
        if (rdy32 !== 1'b1 || vld32 !== 1'b0) begin
            $display("FAIL %s_accept: in_ready=%b out_valid=%b, required 1/0", name, rdy32, vld32);
        end else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (vld32 !== 1'b1 || vld64 !== 1'b1 || imm32 !== x32 || imm64 !== x64 ||
            ill32 !== xill || ill64 !== xill || tag32 !== tag || tag64 !== tag) begin
            $display("FAIL %s: valid=%b/%b imm=%h/%h ill=%b/%b tag=%h/%h, required 1 imm=%h/%h ill=%b tag=%h",
                     name, vld32, vld64, imm32, imm64, ill32, ill64, tag32, tag64, x32, x64, xill, tag);
        end else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
            $display("FAIL %s_drain: out_valid=%b/%b after pop, required 0", name, vld32, vld64);
        end else n_pass++;
    endtask

    task automatic test_directed();
        test_vector("i_type",   32'hFFF00093, 4'd0, 5'h01, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        test_vector("u_type",   32'h123450B7, 4'd3, 5'h1D, 32'h12345000, 64'h00000000_12345000, 1'b0);
        test_vector("b_type",   32'hFE000EE3, 4'd2, 5'h1D, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        test_vector("reserved", 32'hFFFFFFFF, 4'hF, 5'h0A, 32'h0,        64'h0,                 1'b1);
        test_vector("shamt",    32'h03F00013, 4'd5, 5'h03, 32'h0000001F, 64'h00000000_0000003F, 1'b0);
        test_vector("u_neg",    32'h800000B7, 4'd3, 5'h04, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
`ifdef IMM_GEN_RVC_EN
        test_vector("c_addi",   32'h0000107D, 4'd8, 5'h05, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
`else
        test_vector("rvc_off",  32'h0000107D, 4'd8, 5'h05, 32'h0,        64'h0,                 1'b1);
`endif
    endtask

    // Three items against a stalled output: two fit, the third waits
    task automatic test_backpressure();
        sb_t exp[3];
        int  got;
        int  budget;
        bit  third_in;
        exp[0] = mk_item(32'hFFF00093, 4'd0, 5'h11);
        exp[1] = mk_item(32'h123450B7, 4'd3, 5'h12);
        exp[2] = mk_item(32'hFE000EE3, 4'd2, 5'h13);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid   = 1'b1;
            in_instr   = (k == 0) ? 32'hFFF00093 : (k == 1) ? 32'h123450B7 : 32'hFE000EE3;
            in_imm_src = (k == 0) ? 4'd0 : (k == 1) ? 4'd3 : 4'd2;
            in_tag     = 5'(5'h11 + k);
            @(negedge clk);
            n_checks++;
            if (rdy32 !== (k < 2) || rdy64 !== (k < 2)) begin
                $display("FAIL bp_ready_%0d: in_ready=%b/%b, required %b", k, rdy32, rdy64, k < 2);
            end else n_pass++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        got       = 0;
        third_in  = 1'b0;
        budget    = 0;
        while (got < 3 && budget < 12) begin
            @(negedge clk);
            if (in_valid && rdy32) third_in = 1'b1;
            if (vld32 && out_ready) begin
                n_checks++;
                if (imm32 !== exp[got].e32 || imm64 !== exp[got].e64 || tag32 !== exp[got].tag ||
                    ill32 !== exp[got].ill) begin
                    $display("FAIL bp_order_%0d: imm=%h/%h tag=%h ill=%b, required imm=%h/%h tag=%h ill=%b",
                             got, imm32, imm64, tag32, ill32, exp[got].e32, exp[got].e64, exp[got].tag, exp[got].ill);
                end else n_pass++;
                got++;
            end
            @(posedge clk); #1;
            if (third_in) in_valid = 1'b0;
            budget++;
        end
        n_checks++;
        if (got != 3 || !third_in) begin
            $display("FAIL bp_complete: delivered %0d accepted_third=%0b, required 3 and 1", got, third_in);
        end else n_pass++;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Continuous stream with downstream always ready: one item per cycle
    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        int budget = 0;
        q.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        while ((sent < 16 || got < sent) && budget < 40) begin
            if (sent < 16) begin
                in_valid   = 1'b1;
                in_instr   = $urandom;
                in_imm_src = rand_src();
                in_tag     = 5'($urandom);
            end else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid) begin
                n_checks++;
                if (rdy32 !== 1'b1) begin
                    $display("FAIL b2b_ready: in_ready=%b at item %0d, required 1", rdy32, sent);
                end else n_pass++;
                if (rdy32) begin
                    q.push_back(mk_item(in_instr, in_imm_src, in_tag));
                    sent++;
                end
            end
            if (vld32) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_extra: imm=%h with nothing pending, required no output", imm32);
                end else if (imm32 !== q[0].e32 || imm64 !== q[0].e64 || tag32 !== q[0].tag || ill32 !== q[0].ill) begin
                    $display("FAIL b2b_data: imm=%h/%h tag=%h ill=%b, required imm=%h/%h tag=%h ill=%b",
                             imm32, imm64, tag32, ill32, q[0].e32, q[0].e64, q[0].tag, q[0].ill);
                end else n_pass++;
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            @(posedge clk); #1;
            budget++;
        end
        n_checks++;
        if (got != 16 || sent != 16) begin
            $display("FAIL b2b_count: sent %0d delivered %0d, required 16/16", sent, got);
        end else n_pass++;
        in_valid = 1'b0;
    endtask

    // Random handshakes on both sides against the queue model
    task automatic test_random();
        logic        stall;
        logic [31:0] p32;
        logic [63:0] p64;
        logic [4:0]  ptag;
        logic        pill;
        int          errs_before;
        stall = 1'b0;
        p32 = '0; p64 = '0; ptag = '0; pill = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!(in_valid && !rdy32)) begin
                in_valid   = ($urandom_range(0, 9) < 7);
                in_instr   = $urandom;
                in_imm_src = rand_src();
                in_tag     = 5'($urandom);
            end
            out_ready = (cyc >= 560) ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (cyc >= 550) in_valid = 1'b0;
            @(negedge clk);
            if (rdy32 !== rdy64 || vld32 !== vld64) begin
                n_checks++;
                $display("FAIL rand_lockstep: ready=%b/%b valid=%b/%b, required equal", rdy32, rdy64, vld32, vld64);
            end
            if (stall) begin
                n_checks++;
                if (vld32 !== 1'b1 || imm32 !== p32 || imm64 !== p64 || tag32 !== ptag || ill32 !== pill) begin
                    $display("FAIL rand_hold: valid=%b imm=%h/%h tag=%h ill=%b, required 1 imm=%h/%h tag=%h ill=%b",
                             vld32, imm32, imm64, tag32, ill32, p32, p64, ptag, pill);
                end else n_pass++;
            end
            if (in_valid && rdy32) q.push_back(mk_item(in_instr, in_imm_src, in_tag));
            if (vld32 && out_ready) begin
                n_checks++;
                errs_before = n_checks - n_pass;
                if (q.size() == 0) begin
                    $display("FAIL rand_extra: imm=%h with nothing pending, required no output", imm32);
                end else if (imm32 !== q[0].e32 || imm64 !== q[0].e64 || tag32 !== q[0].tag ||
                             tag64 !== q[0].tag || ill32 !== q[0].ill || ill64 !== q[0].ill) begin
                    $display("FAIL rand_data: imm=%h/%h tag=%h/%h ill=%b/%b, required imm=%h/%h tag=%h ill=%b",
                             imm32, imm64, tag32, tag64, ill32, ill64, q[0].e32, q[0].e64, q[0].tag, q[0].ill);
                end else n_pass++;
                if (q.size() != 0) void'(q.pop_front());
            end
            stall = vld32 && !out_ready;
            p32 = imm32; p64 = imm64; ptag = tag32; pill = ill32;
            @(posedge clk); #1;
        end
        n_checks++;
        if (q.size() != 0 || vld32 !== 1'b0) begin
            $display("FAIL rand_drain: %0d items undelivered, out_valid=%b, required 0/0", q.size(), vld32);
        end else n_pass++;
        in_valid = 1'b0;
    endtask

    // Reset while two items are buffered: nothing may come out afterwards
    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid   = 1'b1;
            in_instr   = $urandom;
            in_imm_src = 4'd0;
            in_tag     = 5'(k + 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (vld32 !== 1'b1 || rdy32 !== 1'b0) begin
            $display("FAIL mid_full: out_valid=%b in_ready=%b, required 1/0", vld32, rdy32);
        end else n_pass++;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (vld32 !== 1'b0 || vld64 !== 1'b0 || rdy32 !== 1'b0 || imm32 !== 32'h0 || tag32 !== 5'h0) begin
            $display("FAIL mid_reset: valid=%b/%b ready=%b imm=%h tag=%h, required all zero",
                     vld32, vld64, rdy32, imm32, tag32);
        end else n_pass++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (vld32 || vld64) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            $display("FAIL mid_ghost: out_valid=1 after reset release, required 0");
        end else n_pass++;
        q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imm_gen_pipe
`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 5, width of a sideband tag passed through unchanged (e.g. rd index).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream presents instr/imm_src/tag.
REQ-006 in_ready  output  1  block accepts an item this cycle; a transfer occurs when in_valid && in_ready.
REQ-007 in_instr  input  32  raw instruction word.
REQ-008 in_imm_src  input  4  immediate format select (imm_src_e).
REQ-009 in_tag  input  TAG_W  sideband tag.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-012 out_imm  output  XLEN  extended immediate.
REQ-013 out_tag  output  TAG_W  tag of the item on out_imm.
REQ-014 out_illegal  output  1  imm_src was reserved or disabled; out_imm is 0 for that item.

Function
REQ-015 Encodings: 0 I=sext(I[31:20]); 1 S=sext({I[31:25],I[11:7]}); 2 B=sext({I[31],I[7],I[30:25],I[11:8],0}); 3 U=sext({I[31:12],12'h000}); 4 J=sext({I[31],I[19:12],I[20],I[30:21],0}); 5 SHAMT=zext(I[24:20]) at XLEN=32, zext(I[25:20]) at XLEN=64; 6 ZIMM=zext(I[19:15]) for CSR*I.
REQ-016 sext/zext extend to XLEN; U-type at XLEN=64 sign-extends from bit 31.
REQ-017 Codes 7-15 are reserved unless enabled by REQ-030; a reserved code yields out_imm=0, out_illegal=1, still consumes one slot and is delivered in order.
REQ-018 Decode is registered: an item accepted in cycle N is at the earliest on out_* in cycle N+1 (latency 1).
REQ-019 Buffering is a 2-entry skid FIFO; throughput is one item per cycle when out_ready stays high.
REQ-020 in_ready is a registered signal, 1 when at least one entry is free at the start of the cycle; 0 when both are full.
REQ-021 While out_valid=1 and out_ready=0, out_imm, out_tag and out_illegal hold stable.
REQ-022 Items leave in acceptance order; none dropped or duplicated.
REQ-023 Simultaneous push and pop with one entry occupied keeps occupancy at one and moves the new item behind the current head.
REQ-024 Push when empty with out_ready=1 delivers in the next cycle; the entry frees on that pop.
REQ-025 in_valid while in_ready=0 is ignored; upstream holds its data.

Reset
REQ-026 On rst_n low, asynchronously: FIFO empty, out_valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=0.
REQ-027 in_ready rises in the first clk edge after rst_n deasserts.
REQ-028 Reset mid-operation discards all buffered items; none appear after release.

Configuration
REQ-029 Macro IMM_GEN_RVC_EN controls compressed-immediate support.
REQ-030 Defined: codes 8 CI=sext({I[12],I[6:2]}), 9 CB=sext({I[12],I[6:5],I[2],I[11:10],I[4:3],0}), 10 CJ=sext({I[12],I[8],I[10:9],I[6],I[7],I[2],I[11],I[5:3],0}) are legal.
REQ-031 Not defined: codes 8-10 are reserved per REQ-017.

Structure
REQ-032 Package imm_pkg holds typedef enum imm_src_e (4-bit) and constants IMM_FIFO_DEPTH=2, XLEN_MAX=64.
REQ-033 The combinational format decode is sub-module imm_gen_core (instr, imm_src -> imm, illegal); imm_gen_pipe adds the FIFO and handshake.

Verification
REQ-034 XLEN=32, I, instr 0xFFF00093, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_illegal=0.
REQ-035 U, instr 0x123450B7 -> 0x12345000; B, instr 0xFE000EE3 -> 0xFFFFFFFC; tag 5'h1D passes unchanged.
REQ-036 out_ready=0, 3 consecutive in_valid items -> 2 accepted, in_ready=0 on the third; release out_ready -> items appear in order, third accepted afterwards.
REQ-037 imm_src=4'hF -> out_imm=0, out_illegal=1; with IMM_GEN_RVC_EN, code 8, instr 0x0000107D (c.addi x0,-1) -> 0xFFFFFFFF.
REQ-038 XLEN=64, SHAMT, I[25:20]=6'h3F -> 0x000000000000003F; U 0x800000B7 -> 0xFFFFFFFF80000000.
REQ-039 Two items buffered, rst_n pulsed low mid-cycle -> out_valid=0 immediately; no item emitted after release.
